// File: rtl/rv_mem_pkg.sv
// Shared encodings for the RV32IM data-memory path: access codes, FSM states,
// access sizes and the byte-enable width.
package rv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unlisted load codes fall back to a word access.
  function automatic size_e load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: load_size = SZ_BYTE;
      F3_LH, F3_LHU: load_size = SZ_HALF;
      default:       load_size = SZ_WORD;
    endcase
  endfunction

  function automatic size_e store_size(input logic [1:0] code);
    case (code)
      ST_SB:   store_size = SZ_BYTE;
      ST_SH:   store_size = SZ_HALF;
      default: store_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM: one byte-wide bank per lane, synchronous write with
// per-lane enable and a registered read port.
module dmem_array
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [BE_W-1:0] be_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [31:0]     wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [31:0]     rdata_o
);

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (we_i && be_i[gi]) begin
          lane_mem[waddr_i] <= wdata_i[8*gi +: 8];
        end
        rd_q <= lane_mem[raddr_i];
      end

      assign rdata_o[8*gi +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle MEM-stage data memory responder with busywait stall and load extension.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_read,
  input  logic [2:0]  mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busywait,
  output logic        misalign_err
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW+1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             is_store_q, is_store_d;
  size_e            size_q, size_d;
  logic             uns_q, uns_d;
  logic [31:0]      read_data_q, read_data_d;

  logic             req;
  logic             access;
  logic             misalign;
  logic             we;
  logic [1:0]       lane;
  logic [BE_W-1:0]  be;
  logic [31:0]      wword;
  logic [31:0]      ram_rdata;
  logic [31:0]      load_val;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [AW-1:0]    raddr;
  logic             unused_addr;

  assign unused_addr = ^address[31:AW+2];

  assign req    = mem_read[3] | mem_write[2];
  assign access = (state_q == S_BUSY) && (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_store_d = is_store_q;
    size_d     = size_q;
    uns_d      = uns_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d     = address[AW+1:0];
          wdata_d    = write_data;
          is_store_d = mem_write[2];
          size_d     = mem_write[2] ? store_size(mem_write[1:0]) : load_size(mem_read[2:0]);
          uns_d      = mem_read[2];
          cnt_d      = CNT_W'(LATENCY - 1);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busywait = ((state_q == S_IDLE) && req) || (state_q == S_BUSY);

  // Effective byte lane; without the trap, sub-word offsets are simply dropped.
  always_comb begin
    lane     = addr_q[1:0];
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (size_q)
      SZ_HALF: misalign = addr_q[0];
      SZ_WORD: misalign = |addr_q[1:0];
      default: misalign = 1'b0;
    endcase
`else
    case (size_q)
      SZ_HALF: lane = {addr_q[1], 1'b0};
      SZ_WORD: lane = 2'b00;
      default: lane = addr_q[1:0];
    endcase
`endif
  end

  always_comb begin
    be    = '0;
    wword = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        be    = BE_W'(1) << lane;
        wword = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign we = access && is_store_q && !misalign && !rst;

  // The array's registered read needs the address one cycle ahead, so in IDLE
  // it is fed straight from the request; afterwards from the latched copy.
  assign raddr = (state_q == S_IDLE) ? address[AW+1:2] : addr_q[AW+1:2];

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .be_i    (be),
    .waddr_i (addr_q[AW+1:2]),
    .wdata_i (wword),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    ld_byte  = ram_rdata[{lane, 3'b000} +: 8];
    ld_half  = lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_val = ram_rdata;
    case (size_q)
      SZ_BYTE: load_val = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_val = ram_rdata;
    endcase
  end

  always_comb begin
    read_data_d = read_data_q;
    if (access && !is_store_q && !misalign) begin
      read_data_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_store_q  <= 1'b0;
      size_q      <= SZ_WORD;
      uns_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_store_q  <= is_store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign misalign_d = access && misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised self-checking bench for data_mem_ctrl against a byte-array reference model.
module tb_data_mem_ctrl;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        busywait;
  logic        misalign_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0]  mdl_mem [DEPTH*4];
  logic [31:0] mdl_rd;
  logic        mdl_err;

  data_mem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .busywait    (busywait),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: little-endian byte memory, sizes and extension from the ISA rules.
  task automatic model_apply(input logic [3:0] rd, input logic [2:0] wr,
                             input logic [31:0] a, input logic [31:0] wd);
    int nb;
    int b;
    logic [31:0] v;
    logic is_st;
    is_st = wr[2];
    if (is_st) nb = (wr[1:0] == 2'b00) ? 1 : (wr[1:0] == 2'b01) ? 2 : 4;
    else if (rd[2:0] == 3'b000 || rd[2:0] == 3'b100) nb = 1;
    else if (rd[2:0] == 3'b001 || rd[2:0] == 3'b101) nb = 2;
    else nb = 4;
    b = int'(a[9:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
    mdl_err = (b % nb) != 0;
`else
    b = b - (b % nb);
    mdl_err = 1'b0;
`endif
    if (!mdl_err) begin
      if (is_st) begin
        for (int k = 0; k < nb; k++) mdl_mem[b + k] = wd[8*k +: 8];
      end else if (rd[3]) begin
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (32'(mdl_mem[b + k]) << (8 * k));
        if (nb < 4 && !rd[2] && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        mdl_rd = v;
      end
    end
  endtask

  task automatic do_access(input logic [3:0] rd, input logic [2:0] wr,
                           input logic [31:0] a, input logic [31:0] wd, input string tag);
    int n;
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    address    = a;
    write_data = wd;
    model_apply(rd, wr, a, wd);
    n = 0;
    #1;
    while (busywait === 1'b1 && n < 3 * LAT + 8) begin
      n++;
      @(negedge clk);
      #1;
    end
    check_eq({tag, "/stall"}, 32'(n), 32'(LAT + 1));
    check_eq({tag, "/rdata"}, read_data, mdl_rd);
    check_eq({tag, "/merr"}, {31'b0, misalign_err}, {31'b0, mdl_err});
    mem_read  = '0;
    mem_write = '0;
  endtask

  initial begin
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] a;
    rst        = 1'b1;
    mem_read   = '0;
    mem_write  = '0;
    address    = '0;
    write_data = '0;
    mdl_rd     = '0;
    mdl_err    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst/busy", {31'b0, busywait}, 32'd0);
    check_eq("rst/rdata", read_data, 32'd0);
    check_eq("rst/merr", {31'b0, misalign_err}, 32'd0);
    rst = 1'b0;

    for (int w = 0; w < 16; w++) do_access(4'b0000, 3'b110, 32'(w * 4), $urandom, "init");

    // Directed sequence from the access scenarios
    do_access(4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, "sw10");
    do_access(4'b1010, 3'b000, 32'h10, 32'h0, "lw10");
    check_eq("lw10/const", read_data, 32'hDEADBEEF);
    do_access(4'b0000, 3'b100, 32'h13, 32'h80, "sb13");
    do_access(4'b1000, 3'b000, 32'h13, 32'h0, "lb13");
    check_eq("lb13/const", read_data, 32'hFFFFFF80);
    do_access(4'b1100, 3'b000, 32'h13, 32'h0, "lbu13");
    check_eq("lbu13/const", read_data, 32'h00000080);
    do_access(4'b1010, 3'b000, 32'h10, 32'h0, "lw10b");
    check_eq("lw10b/const", read_data, 32'h80ADBEEF);
    do_access(4'b0000, 3'b101, 32'h12, 32'h1234, "sh12");
    do_access(4'b1101, 3'b000, 32'h12, 32'h0, "lhu12");
    check_eq("lhu12/const", read_data, 32'h00001234);
    do_access(4'b0000, 3'b101, 32'h12, 32'h8001, "sh12b");
    do_access(4'b1001, 3'b000, 32'h12, 32'h0, "lh12");
    check_eq("lh12/const", read_data, 32'hFFFF8001);
    do_access(4'b1010, 3'b110, 32'h14, 32'hCAFEF00D, "ldst");
    do_access(4'b1010, 3'b000, 32'h14, 32'h0, "lw14");

    // Request held continuously: two accesses with one idle cycle between them
    @(negedge clk);
    mem_read = 4'b1010;
    address  = 32'h14;
    model_apply(4'b1010, 3'b000, 32'h14, 32'h0);
    for (int i = 0; i < 2 * (LAT + 2); i++) begin
      #1;
      check_eq("b2b/busy", {31'b0, busywait}, {31'b0, (i % (LAT + 2)) < (LAT + 1)});
      if (i == 2 * (LAT + 2) - 1) mem_read = '0;
      else @(negedge clk);
    end
    check_eq("b2b/rdata", read_data, mdl_rd);

    // Reset in the middle of a store's busy window discards it
    @(negedge clk);
    mem_write  = 3'b110;
    address    = 32'h20;
    write_data = 32'h55;
    @(negedge clk);
    rst       = 1'b1;
    mem_write = '0;
    @(negedge clk);
    #1;
    check_eq("rstmid/busy", {31'b0, busywait}, 32'd0);
    check_eq("rstmid/rdata", read_data, 32'd0);
    rst    = 1'b0;
    mdl_rd = '0;
    do_access(4'b1010, 3'b000, 32'h20, 32'h0, "lw20");
    do_access(4'b1010, 3'b000, 32'h21, 32'h0, "lw21");

    for (int t = 0; t < 150; t++) begin
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        wr = {1'b1, 2'($urandom_range(0, 3))};
        rd = 4'($urandom);
      end else begin
        wr = {1'b0, 2'($urandom)};
        rd = {1'b1, 3'($urandom)};
      end
      do_access(rd, wr, a, $urandom, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data-memory responder for the RV32IM pipeline's MEM stage. It accepts load/store requests carried by the EX/MEM pipeline register, performs byte/half/word accesses on an internal word-organised array, and drives `busywait`, which stalls every pipeline register until the access completes. Loads return a sign- or zero-extended 32-bit value to the MEM/WB register.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two.
- `LATENCY`, 2: array access cycles, ≥1.
- `clk  in  1`: single clock, all state on posedge.
- `rst  in  1`: synchronous, active-high reset.
- `mem_read  in  4`: bit3 = load enable; bits[2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `mem_write  in  3`: bit2 = store enable; bits[1:0]: 00 SB, 01 SH, 10 SW.
- `address  in  32`: byte address; word index = `address[log2(DEPTH_WORDS)+1:2]`, upper bits ignored (wrap).
- `write_data  in  32`: store data, low bits used for SB/SH.
- `read_data  out  32`: extended load result.
- `busywait  out  1`: stall request to all pipeline registers.
- `misalign_err  out  1`: one-cycle misalignment flag; tied 0 when the feature is compiled out.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Request present when `mem_read[3]` or `mem_write[2]` is set.
  - On a request, `busywait` = 1 combinationally in the same cycle.
  - Latch address, write_data and type; load counter with LATENCY−1; go to BUSY.
- BUSY:
  - `busywait` = 1; counter decrements each cycle.
  - At count 0, perform the access: store with byte enables, or capture load data. Go to DONE.
- DONE:
  - `busywait` = 0; `read_data` valid.
  - The request still visible on inputs this cycle is ignored (already served).
  - Return to IDLE.
- Load and store asserted together: store wins; load ignored; `read_data` unchanged.
- Invalid funct3 codes (011, 11x) are treated as LW; store code 11 is treated as SW.
- Lane selection:
  - Bytes use `address[1:0]`.
  - Halves use `address[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- `read_data` holds its value until the next load completes. It does not change on stores.
- Array contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `busywait` 0, `read_data` 0, `misalign_err` 0, counter 0.
- Request in cycle N: `busywait` high in cycles N..N+LATENCY (LATENCY+1 cycles) and low in N+LATENCY+1 (DONE).
  - Store visible in the array from the posedge ending N+LATENCY.
  - Load data on `read_data` from that same posedge.
- Back-to-back: a new request is recognised only in IDLE, so the minimum gap between two accepted requests is LATENCY+2 cycles.
- `rst` in any state: next cycle is IDLE with `busywait` 0.
  - A pending store is discarded if reset arrives before its count reaches 0.
- No request in IDLE: `busywait` 0; outputs hold.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `address[0]` = 1, or LW/SW with `address[1:0]` ≠ 0, is misaligned.
  - A misaligned store is suppressed; a misaligned load leaves `read_data` unchanged.
  - `misalign_err` = 1 for exactly the DONE cycle.
  - Timing is unchanged.
- Undefined:
  - Halfword accesses force `address[0]` to 0; word accesses force `address[1:0]` to 0.
  - `misalign_err` is constant 0.

## Structure
- Shared package `rv_mem_pkg`:
  - load funct3 constants and store codes;
  - FSM state typedef (IDLE/BUSY/DONE);
  - byte-enable width constant.
- Sub-module `dmem_array`:
  - synchronous-write word RAM with 4-bit byte enable;
  - registered read port, addressed by word index.
- Lane steering, extension and the FSM live in `data_mem_ctrl`.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 with LATENCY=2 → `busywait` high 3 cycles per access; `read_data` = 0xDEADBEEF in DONE.
- SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80ADBEEF.
- SH 0x1234 to 0x12, then LHU 0x12 → 0x00001234; LH 0x12 after SH 0x8001 → 0xFFFF8001.
- Hold the request on inputs through DONE → exactly one access; IDLE re-triggers only in the cycle after DONE; stall count verified for two back-to-back loads.
- Assert `rst` mid-BUSY of SW 0x55 to 0x20 → next cycle `busywait` 0; LW 0x20 returns the prior value (store discarded).
- LW 0x21:
  - macro defined → `misalign_err` pulse in DONE, `read_data` unchanged;
  - macro undefined → returns word at 0x20, `misalign_err` 0.
